// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Bit-serial operand-2 shifter with ARM barrel-shift semantics
//   (LSL, LSR, ASR, ROR) and shifter carry-out. It performs one 1-bit
//   shift per clock for the requested amount. A start/busy/done handshake
//   lets the control unit stall until the result is valid.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   request, sampled only while idle
//   shift_type in   00=LSL 01=LSR 10=ASR 11=ROR
//   amount     in   requested shift amount (AMT_W bits)
//   operand    in   value to shift (WIDTH bits)
//   carry_in   in   current C flag, returned unchanged for amount 0
//   result     out  shifted value, held until the next accepted start
//   carry_out  out  shifter carry-out, held with result
//   busy       out  high whenever the sequencer is not idle
//   done       out  one-cycle pulse: result/carry_out valid
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       shift_type,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] operand,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ASR = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

  state_t           state_q, state_d;
  logic [5:0]       count_q, count_d;
  logic [1:0]       type_q, type_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [5:0]       iter_n;

  // Iteration count for a new request. Linear shifts saturate at 33: one
  // step past the width already yields the final value (0 or all-sign) and
  // carry. Rotation only depends on amount mod 32, except that a nonzero
  // multiple of 32 still does a full turn so carry picks up bit[31].
  always_comb begin
    iter_n = '0;
    if (shift_type == T_ROR) begin
      if (amount[4:0] != 5'd0)
        iter_n = {1'b0, amount[4:0]};
      else if (amount != '0)
        iter_n = 6'd32;
      else
        iter_n = '0;
    end else begin
      if (amount > AMT_W'(33))
        iter_n = 6'd33;
      else
        iter_n = amount[5:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    type_d   = type_q;
    result_d = result_q;
    carry_d  = carry_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          result_d = operand;
          carry_d  = carry_in;
          type_d   = shift_type;
          count_d  = iter_n;
          state_d  = (iter_n != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        unique case (type_q)
          T_LSL: begin
            result_d = {result_q[WIDTH-2:0], 1'b0};
            carry_d  = result_q[WIDTH-1];
          end
          T_LSR: begin
            result_d = {1'b0, result_q[WIDTH-1:1]};
            carry_d  = result_q[0];
          end
          T_ASR: begin
            result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            carry_d  = result_q[0];
          end
          T_ROR: begin
            result_d = {result_q[0], result_q[WIDTH-1:1]};
            carry_d  = result_q[0];
          end
          default: ;
        endcase
        count_d = count_q - 6'd1;
        if (count_q == 6'd1)
          state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      type_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      type_q   <= type_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign result    = result_q;
  assign carry_out = carry_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule
